// File: rtl/axis_tx_pkg.sv
// Shared encodings for the packet arbiter in front of the RS232 transmitter.
package axis_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    localparam logic [3:0] HDR_TAG   = 4'hA;
    localparam int         MAX_PORTS = 16;

endpackage

// File: rtl/axis_tx_arbiter_rr_select.sv
// Round-robin selector: first set request strictly after the last-served index,
// wrapping modulo PORTS, found by masking a doubled request vector.
module rr_select #(
    parameter int PORTS = 4,
    parameter int IDW   = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             any,
    output logic [IDW-1:0]   index
);

    logic [2*PORTS-1:0] dbl;
    logic [2*PORTS-1:0] mask;
    logic [2*PORTS-1:0] hit;

    always_comb begin
        dbl  = {req, req};
        mask = '0;
        for (int i = 0; i < 2 * PORTS; i++) begin
            if (i > int'(last) && i <= int'(last) + PORTS) begin
                mask[i] = 1'b1;
            end
        end
        hit   = dbl & mask;
        index = '0;
        // Scan downwards so the lowest masked hit is the one left standing.
        for (int i = 2 * PORTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                index = IDW'(i % PORTS);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte stream sink among PORTS sources.
// Optional header byte per packet when AXIS_TX_ARBITER_HEADER_EN is defined.
module axis_tx_arbiter
    import axis_tx_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDW   = $clog2(PORTS)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [8*PORTS-1:0] idata,
    input  logic [PORTS-1:0]   ivalid,
    input  logic [PORTS-1:0]   ilast,
    output logic [PORTS-1:0]   iready,
    output logic [7:0]         odata,
    output logic               ovalid,
    input  logic               oready,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_ptr;
    logic           load_ok;
    logic           load;
    logic [7:0]     load_data;
    logic           sel_any;
    logic [IDW-1:0] sel_idx;
    logic [7:0]     src_byte;
    logic           src_valid;
    logic           src_last;
    logic           src_xfer;

    assign load_ok  = !ovalid || oready;
    assign busy     = (state != ST_IDLE);
    assign src_xfer = (state == ST_PASS) && src_valid && load_ok;

    rr_select #(
        .PORTS (PORTS),
        .IDW   (IDW)
    ) u_rr_select (
        .req   (ivalid),
        .last  (last_ptr),
        .any   (sel_any),
        .index (sel_idx)
    );

    // Only the granted requester's lane is ever looked at.
    always_comb begin
        src_byte  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (grant_id == IDW'(k)) begin
                src_byte  = idata[8*k +: 8];
                src_valid = ivalid[k];
                src_last  = ilast[k];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        iready    = '0;
        load      = 1'b0;
        load_data = src_byte;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
`ifdef AXIS_TX_ARBITER_HEADER_EN
                    state_nxt = ST_HDR;
`else
                    state_nxt = ST_PASS;
`endif
                end
            end
`ifdef AXIS_TX_ARBITER_HEADER_EN
            ST_HDR: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_data = {HDR_TAG, 4'(grant_id)};
                    state_nxt = ST_PASS;
                end
            end
`endif
            ST_PASS: begin
                for (int k = 0; k < PORTS; k++) begin
                    if (grant_id == IDW'(k)) begin
                        iready[k] = load_ok;
                    end
                end
                if (src_xfer) begin
                    load = 1'b1;
                    if (src_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointer starts at PORTS-1 so requester 0 is searched first after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            last_ptr <= IDW'(PORTS - 1);
            ovalid   <= 1'b0;
            odata    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && sel_any) begin
                grant_id <= sel_idx;
            end
            if (src_xfer && src_last) begin
                last_ptr <= grant_id;
            end
            if (load) begin
                odata  <= load_data;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Bench for axis_tx_arbiter: cycle table, directed corner sequences and
// randomized traffic against a packet-level round-robin model.
module tb_axis_tx_arbiter;

    localparam int PORTS = 4;
    localparam int IDW   = 2;

    logic               clock = 1'b0;
    logic               resetn;
    logic [8*PORTS-1:0] idata;
    logic [PORTS-1:0]   ivalid;
    logic [PORTS-1:0]   ilast;
    logic [PORTS-1:0]   iready;
    logic [7:0]         odata;
    logic               ovalid;
    logic               oready;
    logic [IDW-1:0]     grant_id;
    logic               busy;

    always #5 clock = ~clock;

    axis_tx_arbiter #(.PORTS(PORTS)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .idata    (idata),
        .ivalid   (ivalid),
        .ilast    (ilast),
        .iready   (iready),
        .odata    (odata),
        .ovalid   (ovalid),
        .oready   (oready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int ohviol = 0;

    logic [8:0] srcq [PORTS][$];
    logic [7:0] expq [$];
    logic [7:0] monq [$];
    bit         mon_en = 1'b0;
    int         seq = 0;

    typedef struct packed {
        logic [3:0]  iv;
        logic [31:0] d;
        logic [3:0]  il;
        logic        ordy;
        logic        ev;
        logic [7:0]  ed;
        logic        eb;
        logic [3:0]  er;
        logic [1:0]  eg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always begin
        @(negedge clock);
        #2;
        if (mon_en && ovalid && oready) monq.push_back(odata);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        ivalid = '0;
        ilast  = '0;
        idata  = '0;
        oready = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic push_byte(input int p, input logic [7:0] d, input logic l);
        srcq[p].push_back({l, d});
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            push_byte(p, 8'((p << 6) | (seq & 63)), (i == len - 1));
            seq++;
        end
    endtask

    // Whole packets leave in round-robin order among ports that still hold packets.
    task automatic build_expected(input int start_last);
        logic [8:0] q [PORTS][$];
        logic [8:0] w;
        int ptr;
        int found;
        for (int k = 0; k < PORTS; k++) q[k] = srcq[k];
        ptr = start_last;
        forever begin
            found = -1;
            for (int s = 1; s <= PORTS; s++) begin
                if (found < 0 && q[(ptr + s) % PORTS].size() > 0) found = (ptr + s) % PORTS;
            end
            if (found < 0) break;
`ifdef AXIS_TX_ARBITER_HEADER_EN
            expq.push_back(8'hA0 | 8'(found));
`endif
            do begin
                w = q[found].pop_front();
                expq.push_back(w[7:0]);
            end while (!w[8]);
            ptr = found;
        end
    endtask

    task automatic run_traffic(input bit rnd, input int budget, input string name, output int gaps);
        bit         mid  [PORTS];
        bit         fire [PORTS];
        logic [8:0] w;
        logic [7:0] e;
        int         cyc = 0;
        bit         started = 1'b0;
        gaps = 0;
        for (int k = 0; k < PORTS; k++) begin
            mid[k]  = 1'b0;
            fire[k] = 1'b0;
        end
        while (expq.size() > 0 && cyc < budget) begin
            @(negedge clock);
            for (int k = 0; k < PORTS; k++) begin
                if (fire[k]) begin
                    w = srcq[k].pop_front();
                    mid[k] = !w[8];
                end
            end
            for (int k = 0; k < PORTS; k++) begin
                if (srcq[k].size() > 0) begin
                    w = srcq[k][0];
                    ivalid[k] = (rnd && mid[k]) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    idata[8*k +: 8] = w[7:0];
                    ilast[k] = w[8];
                end else begin
                    ivalid[k] = 1'b0;
                    idata[8*k +: 8] = 8'h00;
                    ilast[k] = 1'b0;
                end
            end
            oready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if ((iready & (iready - 1'b1)) != '0) ohviol++;
            for (int k = 0; k < PORTS; k++) fire[k] = ivalid[k] && iready[k];
            if (ovalid && oready) begin
                started = 1'b1;
                e = expq.pop_front();
                check({name, "_byte"}, 32'(odata), 32'(e));
            end else if (started && !ovalid) begin
                gaps++;
            end
            cyc++;
        end
        check({name, "_drained"}, expq.size(), 0);
        @(negedge clock);
        ivalid = '0;
        ilast  = '0;
        oready = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] iv, input logic [31:0] d, input logic [3:0] il,
                                input logic ordy, input logic ev, input logic [7:0] ed,
                                input logic eb, input logic [3:0] er, input logic [1:0] eg);
        vec_t v;
        v.iv = iv; v.d = d; v.il = il; v.ordy = ordy; v.ev = ev;
        v.ed = ed; v.eb = eb; v.er = er; v.eg = eg;
        return v;
    endfunction

    initial begin
        vec_t       tbl [14];
        logic [7:0] e4 [$];
        int         g;
        bit         got;
        bit         done1;
        bit         done3;
        bit         f1;
        bit         f3;

        resetn = 1'b1;
        ivalid = '0;
        ilast  = '0;
        idata  = '0;
        oready = 1'b1;
        do_reset();
        #1;
        check("reset_state", {ovalid, odata, busy, iready, grant_id}, 32'h0);

`ifndef AXIS_TX_ARBITER_HEADER_EN
        // Port 0 packet 11,22,33 then port 2 packet A1,A2,A3 with a stalled sink.
        tbl[0]  = mk(4'h1, 32'h00000011, 4'h0, 1, 0, 8'h00, 0, 4'h0, 2'd0);
        tbl[1]  = mk(4'h1, 32'h00000011, 4'h0, 1, 0, 8'h00, 1, 4'h1, 2'd0);
        tbl[2]  = mk(4'h1, 32'h00000022, 4'h0, 1, 1, 8'h11, 1, 4'h1, 2'd0);
        tbl[3]  = mk(4'h1, 32'h00000033, 4'h1, 1, 1, 8'h22, 1, 4'h1, 2'd0);
        tbl[4]  = mk(4'h0, 32'h00000000, 4'h0, 1, 1, 8'h33, 0, 4'h0, 2'd0);
        tbl[5]  = mk(4'h0, 32'h00000000, 4'h0, 1, 0, 8'h00, 0, 4'h0, 2'd0);
        tbl[6]  = mk(4'h4, 32'h00A10000, 4'h0, 1, 0, 8'h00, 0, 4'h0, 2'd0);
        tbl[7]  = mk(4'h4, 32'h00A10000, 4'h0, 1, 0, 8'h00, 1, 4'h4, 2'd2);
        tbl[8]  = mk(4'h4, 32'h00A20000, 4'h0, 1, 1, 8'hA1, 1, 4'h4, 2'd2);
        tbl[9]  = mk(4'h4, 32'h00A30000, 4'h4, 0, 1, 8'hA2, 1, 4'h0, 2'd2);
        tbl[10] = mk(4'h4, 32'h00A30000, 4'h4, 0, 1, 8'hA2, 1, 4'h0, 2'd2);
        tbl[11] = mk(4'h4, 32'h00A30000, 4'h4, 1, 1, 8'hA2, 1, 4'h4, 2'd2);
        tbl[12] = mk(4'h0, 32'h00000000, 4'h0, 1, 1, 8'hA3, 0, 4'h0, 2'd2);
        tbl[13] = mk(4'h0, 32'h00000000, 4'h0, 1, 0, 8'h00, 0, 4'h0, 2'd2);
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            ivalid = tbl[i].iv;
            idata  = tbl[i].d;
            ilast  = tbl[i].il;
            oready = tbl[i].ordy;
            #1;
            check($sformatf("table_row%0d", i),
                  {ovalid, (ovalid ? odata : 8'h00), busy, iready, grant_id},
                  {tbl[i].ev, (tbl[i].ev ? tbl[i].ed : 8'h00), tbl[i].eb, tbl[i].er, tbl[i].eg});
        end
`else
        // Single port-2 packet with the header byte in front.
        do_reset();
        push_byte(2, 8'h5A, 1'b0);
        push_byte(2, 8'hC3, 1'b1);
        expq.delete();
        expq.push_back(8'hA2);
        expq.push_back(8'h5A);
        expq.push_back(8'hC3);
        run_traffic(1'b0, 100, "header", g);
`endif

        // All ports requesting: order 0,1,2,3,0 with one idle output cycle per boundary.
        do_reset();
        add_pkt(0, 2);
        add_pkt(1, 2);
        add_pkt(2, 2);
        add_pkt(3, 2);
        add_pkt(0, 2);
        expq.delete();
        build_expected(PORTS - 1);
        run_traffic(1'b0, 300, "rr_order", g);
        check("rr_gaps", g, 4);

        // Granted port 1 goes quiet mid-packet while port 3 waits.
        do_reset();
        monq.delete();
        mon_en = 1'b1;
        @(negedge clock);
        oready = 1'b1;
        ivalid = 4'b1010;
        idata  = '0;
        idata[15:8]  = 8'h41;
        idata[31:24] = 8'h43;
        ilast  = 4'b1000;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            #1;
            if (ivalid[1] && iready[1]) got = 1'b1;
            else @(negedge clock);
        end
        check("p1_first_accept", 32'(got), 1);
        @(negedge clock);
        ivalid[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("p1_hold", {grant_id, iready[3], busy}, {2'd1, 1'b0, 1'b1});
            @(negedge clock);
        end
        ivalid[1] = 1'b1;
        idata[15:8] = 8'h42;
        ilast[1] = 1'b1;
        done1 = 1'b0;
        done3 = 1'b0;
        for (int c = 0; c < 30 && !(done1 && done3); c++) begin
            #1;
            f1 = ivalid[1] && iready[1];
            f3 = ivalid[3] && iready[3];
            @(negedge clock);
            if (f1) begin ivalid[1] = 1'b0; done1 = 1'b1; end
            if (f3) begin ivalid[3] = 1'b0; done3 = 1'b1; end
        end
        check("p1_p3_done", {30'd0, done1, done3}, 32'h3);
        repeat (4) @(negedge clock);
        mon_en = 1'b0;
`ifdef AXIS_TX_ARBITER_HEADER_EN
        e4 = '{8'hA1, 8'h41, 8'h42, 8'hA3, 8'h43};
`else
        e4 = '{8'h41, 8'h42, 8'h43};
`endif
        check("hold_count", monq.size(), e4.size());
        for (int i = 0; i < e4.size() && i < monq.size(); i++) begin
            check($sformatf("hold_byte%0d", i), 32'(monq[i]), 32'(e4[i]));
        end

        // Asynchronous reset while a byte sits in the stalled output register.
        do_reset();
        @(negedge clock);
        oready = 1'b0;
        ivalid = 4'b0001;
        idata  = 32'h00000011;
        ilast  = 4'b0000;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            #1;
            if (ovalid && busy) got = 1'b1;
            else @(negedge clock);
        end
        check("pre_reset_full", 32'(got), 1);
        resetn = 1'b0;
        #1;
        check("reset_midpkt", {ovalid, iready, busy}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        oready = 1'b1;
        ivalid = 4'b0101;
        @(negedge clock);
        #1;
        check("post_reset_grant", {busy, grant_id}, {1'b1, 2'd0});
        ivalid = '0;

        // Randomized traffic with sink stalls and mid-packet source gaps.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < PORTS; p++) begin
                int np;
                np = $urandom_range(1, 4);
                for (int j = 0; j < np; j++) add_pkt(p, $urandom_range(1, 5));
            end
            expq.delete();
            build_expected(PORTS - 1);
            run_traffic(1'b1, 3000, $sformatf("rand%0d", r), g);
        end
        check("iready_onehot", ohviol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
